// File: rtl/pool_window_sequencer.sv
// Pooling window sequencer: captures an HxW feature map into a local buffer, then
// walks KxK windows at stride S and streams one max/mean/min result per window.
module pool_window_sequencer #(
  parameter int MAX_DIM = 8,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        cfg_width,
  input  logic [3:0]        cfg_height,
  input  logic [1:0]        cfg_kernel,
  input  logic [1:0]        cfg_stride,
  input  logic [1:0]        cfg_op,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W  = 4;
  localparam int ADDR_W = $clog2(MAX_DIM * MAX_DIM);
  localparam int SUM_W  = DATA_W + 4;
  localparam logic [CNT_W-1:0] MAX_DIM_C = CNT_W'(MAX_DIM);
  localparam logic [1:0] OP_MAX  = 2'b00;
  localparam logic [1:0] OP_MEAN = 2'b01;
  localparam logic [1:0] OP_MIN  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ACC  = 3'd2,
    ST_OUT  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  function automatic logic [CNT_W-1:0] kernel_size(input logic [1:0] code);
    case (code)
      2'b00:   kernel_size = 4'd1;
      2'b01:   kernel_size = 4'd2;
      2'b10:   kernel_size = 4'd4;
      default: kernel_size = 4'd0;
    endcase
  endfunction

  // Mean divides by K*K, which is always a power of two.
  function automatic logic [2:0] mean_shift(input logic [CNT_W-1:0] k);
    case (k)
      4'd2:    mean_shift = 3'd2;
      4'd4:    mean_shift = 3'd4;
      default: mean_shift = 3'd0;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] buf_addr(input logic [CNT_W-1:0] row,
                                                 input logic [CNT_W-1:0] col);
    buf_addr = ADDR_W'(32'(row) * MAX_DIM + 32'(col));
  endfunction

  state_t state_r, state_s;

  logic [DATA_W-1:0] buf_r [MAX_DIM*MAX_DIM];

  logic [CNT_W-1:0]  w_r, h_r, k_r, s_r;
  logic [1:0]        op_r;
  logic [2:0]        shift_r;
  logic [CNT_W-1:0]  row_r, col_r;
  logic [CNT_W-1:0]  orig_row_r, orig_col_r;
  logic [CNT_W-1:0]  win_row_r, win_col_r;
  logic [SUM_W-1:0]  acc_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_valid_r, out_last_r, in_ready_r, busy_r, done_r, error_r;

  logic [CNT_W-1:0]  k_cfg_s;
  logic              cfg_ok_s;
  logic              beat_s, last_beat_s, win_end_s, col_more_s, row_more_s;
  logic [CNT_W-1:0]  rd_row_s, rd_col_s;
  logic [DATA_W-1:0] elem_s;
  logic [SUM_W-1:0]  elem_ext_s, acc_next_s;
  logic [DATA_W-1:0] result_s;

  // Configuration legality and window geometry decode.
  always_comb begin
    k_cfg_s  = kernel_size(cfg_kernel);
    cfg_ok_s = (cfg_width != 4'd0) && (cfg_width <= MAX_DIM_C) &&
               (cfg_height != 4'd0) && (cfg_height <= MAX_DIM_C) &&
               (cfg_kernel != 2'b11) && (cfg_op != 2'b11) &&
               (k_cfg_s <= cfg_width) && (k_cfg_s <= cfg_height);

    beat_s      = in_valid && in_ready_r;
    last_beat_s = (row_r == h_r - 4'd1) && (col_r == w_r - 4'd1);
    win_end_s   = (win_row_r == k_r - 4'd1) && (win_col_r == k_r - 4'd1);
    // Another window fits to the right / below when origin+S+K stays inside the map.
    col_more_s  = ({1'b0, orig_col_r} + {1'b0, s_r} + {1'b0, k_r}) <= {1'b0, w_r};
    row_more_s  = ({1'b0, orig_row_r} + {1'b0, s_r} + {1'b0, k_r}) <= {1'b0, h_r};

    rd_row_s   = orig_row_r + win_row_r;
    rd_col_s   = orig_col_r + win_col_r;
    elem_s     = buf_r[buf_addr(rd_row_s, rd_col_s)];
    elem_ext_s = SUM_W'(elem_s);
  end

  // Accumulator update and final window result.
  always_comb begin
    acc_next_s = elem_ext_s;
    if ((win_row_r == 4'd0) && (win_col_r == 4'd0)) begin
      acc_next_s = elem_ext_s;
    end else begin
      case (op_r)
        OP_MAX:  acc_next_s = (elem_ext_s > acc_r) ? elem_ext_s : acc_r;
        OP_MEAN: acc_next_s = acc_r + elem_ext_s;
        OP_MIN:  acc_next_s = (elem_ext_s < acc_r) ? elem_ext_s : acc_r;
        default: acc_next_s = elem_ext_s;
      endcase
    end
    if (op_r == OP_MEAN) begin
      result_s = DATA_W'(acc_next_s >> shift_r);
    end else begin
      result_s = DATA_W'(acc_next_s);
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && cfg_ok_s) state_s = ST_LOAD;
        else                   state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (beat_s && last_beat_s) state_s = ST_ACC;
        else                       state_s = ST_LOAD;
      end
      ST_ACC: begin
        if (win_end_s) state_s = ST_OUT;
        else           state_s = ST_ACC;
      end
      ST_OUT: begin
        if (out_ready) state_s = out_last_r ? ST_FIN : ST_ACC;
        else           state_s = ST_OUT;
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Pixel buffer; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if ((state_r == ST_LOAD) && beat_s) buf_r[buf_addr(row_r, col_r)] <= in_data;
  end

  // Configuration, counters, accumulator and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_r         <= 4'd0;
      h_r         <= 4'd0;
      k_r         <= 4'd0;
      s_r         <= 4'd0;
      op_r        <= 2'b00;
      shift_r     <= 3'd0;
      row_r       <= 4'd0;
      col_r       <= 4'd0;
      orig_row_r  <= 4'd0;
      orig_col_r  <= 4'd0;
      win_row_r   <= 4'd0;
      win_col_r   <= 4'd0;
      acc_r       <= '0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      busy_r      <= (state_s == ST_LOAD) || (state_s == ST_ACC) || (state_s == ST_OUT);
      in_ready_r  <= (state_s == ST_LOAD);
      out_valid_r <= (state_s == ST_OUT);
      done_r      <= (state_s == ST_FIN);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok_s) begin
              w_r     <= cfg_width;
              h_r     <= cfg_height;
              k_r     <= k_cfg_s;
              s_r     <= {2'b00, cfg_stride} + 4'd1;
              op_r    <= cfg_op;
              shift_r <= mean_shift(k_cfg_s);
              row_r   <= 4'd0;
              col_r   <= 4'd0;
              error_r <= 1'b0;
            end else begin
              error_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (beat_s) begin
            if (col_r == w_r - 4'd1) begin
              col_r <= 4'd0;
              row_r <= row_r + 4'd1;
            end else begin
              col_r <= col_r + 4'd1;
            end
            if (last_beat_s) begin
              orig_row_r <= 4'd0;
              orig_col_r <= 4'd0;
              win_row_r  <= 4'd0;
              win_col_r  <= 4'd0;
            end
          end
        end
        ST_ACC: begin
          acc_r <= acc_next_s;
          if (win_end_s) begin
            win_row_r  <= 4'd0;
            win_col_r  <= 4'd0;
            out_data_r <= result_s;
            out_last_r <= !col_more_s && !row_more_s;
          end else if (win_col_r == k_r - 4'd1) begin
            win_col_r <= 4'd0;
            win_row_r <= win_row_r + 4'd1;
          end else begin
            win_col_r <= win_col_r + 4'd1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_last_r <= 1'b0;
            if (col_more_s) begin
              orig_col_r <= orig_col_r + s_r;
            end else begin
              orig_col_r <= 4'd0;
              orig_row_r <= orig_row_r + s_r;
            end
          end
        end
        ST_FIN: begin
          row_r <= 4'd0;
          col_r <= 4'd0;
        end
        default: begin
          row_r <= 4'd0;
          col_r <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_pool_window_sequencer.sv
// Self-checking bench for pool_window_sequencer: directed plan cases plus random jobs
// compared against a window-level reference model.
module tb_pool_window_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] cfg_width, cfg_height;
  logic [1:0] cfg_kernel, cfg_stride, cfg_op;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       busy, done, error;

  int total = 0;
  int bad   = 0;

  logic [7:0] pix [64];
  int         exp_q [$];
  int         last_q [$];

  pool_window_sequencer #(.MAX_DIM(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_kernel(cfg_kernel),
    .cfg_stride(cfg_stride), .cfg_op(cfg_op),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ksize(input int code);
    return (code == 0) ? 1 : (code == 1) ? 2 : (code == 2) ? 4 : 0;
  endfunction

  function automatic bit legal(input int w, input int h, input int kc, input int op);
    int k = ksize(kc);
    return (w >= 1) && (w <= 8) && (h >= 1) && (h <= 8) && (kc != 3) && (op != 3) &&
           (k <= w) && (k <= h);
  endfunction

  // Reference: pooled value per window in row-major window order.
  function automatic void model(input int w, input int h, input int k, input int s, input int op);
    int oh = (h - k) / s + 1;
    int ow = (w - k) / s + 1;
    exp_q.delete();
    last_q.delete();
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        int mx = 0;
        int mn = 255;
        int sum = 0;
        for (int y = 0; y < k; y++) begin
          for (int x = 0; x < k; x++) begin
            int v = int'(pix[(oy * s + y) * w + (ox * s + x)]);
            sum += v;
            if (v > mx) mx = v;
            if (v < mn) mn = v;
          end
        end
        exp_q.push_back(op == 0 ? mx : op == 1 ? sum / (k * k) : mn);
        last_q.push_back((oy == oh - 1 && ox == ow - 1) ? 1 : 0);
      end
    end
  endfunction

  task automatic run_job(input int w, input int h, input int kc, input int sc, input int op,
                         input int stall, input bit bubbles);
    int k = ksize(kc);
    int n = w * h;
    int idx = 0;
    int guard = 0;
    int c;
    int acc_total = 0;
    @(negedge clk);
    cfg_width = 4'(w); cfg_height = 4'(h); cfg_kernel = 2'(kc);
    cfg_stride = 2'(sc); cfg_op = 2'(op);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (!legal(w, h, kc, op)) begin
      check_val("rej_error", 32'(error), 32'd1);
      check_val("rej_busy", 32'(busy), 32'd0);
      check_val("rej_in_ready", 32'(in_ready), 32'd0);
      repeat (3) @(negedge clk);
      check_val("rej_out_valid", 32'(out_valid), 32'd0);
      check_val("rej_sticky", 32'(error), 32'd1);
      check_val("rej_done", 32'(done), 32'd0);
      return;
    end
    check_val("start_busy", 32'(busy), 32'd1);
    check_val("start_in_ready", 32'(in_ready), 32'd1);
    check_val("start_error", 32'(error), 32'd0);
    // An illegal start during LOAD must be ignored.
    start = 1'b1;
    cfg_op = 2'b11;
    while (idx < n && guard < 2000) begin
      in_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = in_valid ? pix[idx] : 8'($urandom);
      @(negedge clk);
      start = 1'b0;
      if (in_valid) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check_val("load_beats", 32'(idx), 32'(n));
    model(w, h, k, sc + 1, op);
    for (int i = 0; i < exp_q.size(); i++) begin
      c = 0;
      while (!out_valid && c < 200) begin
        @(negedge clk);
        c++;
      end
      acc_total += c;
      check_val("win_latency", 32'(c), 32'(k * k));
      check_val("out_data", 32'(out_data), 32'(exp_q[i]));
      check_val("out_last", 32'(out_last), 32'(last_q[i]));
      if (i == 0) begin
        for (int j = 0; j < stall; j++) begin
          @(negedge clk);
          check_val("stall_valid", 32'(out_valid), 32'd1);
          check_val("stall_data", 32'(out_data), 32'(exp_q[i]));
          check_val("stall_last", 32'(out_last), 32'(last_q[i]));
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    check_val("acc_cycles", 32'(acc_total), 32'(exp_q.size() * k * k));
    check_val("fin_done", 32'(done), 32'd1);
    check_val("fin_busy", 32'(busy), 32'd0);
    check_val("fin_out_valid", 32'(out_valid), 32'd0);
    check_val("fin_error", 32'(error), 32'd0);
    @(negedge clk);
    check_val("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic reset_mid_load();
    @(negedge clk);
    cfg_width = 4'd4; cfg_height = 4'd4; cfg_kernel = 2'b01;
    cfg_stride = 2'b01; cfg_op = 2'b00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(100 + i);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_out_last", 32'(out_last), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_error", 32'(error), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    cfg_width = 4'd0; cfg_height = 4'd0; cfg_kernel = 2'b00; cfg_stride = 2'b00; cfg_op = 2'b00;
    repeat (2) @(negedge clk);
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_in_ready", 32'(in_ready), 32'd0);
    check_val("reset_out_valid", 32'(out_valid), 32'd0);
    check_val("reset_out_data", 32'(out_data), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_error", 32'(error), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) pix[i] = 8'(i);
    run_job(4, 4, 1, 1, 0, 0, 1'b0);
    run_job(4, 4, 1, 1, 1, 0, 1'b1);
    run_job(4, 4, 1, 1, 2, 0, 1'b0);

    for (int i = 0; i < 9; i++) pix[i] = 8'(i);
    run_job(3, 3, 1, 0, 0, 5, 1'b0);
    run_job(3, 3, 2, 0, 0, 0, 1'b0);
    run_job(3, 3, 1, 0, 2, 0, 1'b1);

    for (int i = 0; i < 64; i++) pix[i] = 8'hFF;
    run_job(8, 8, 2, 3, 1, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 64; i++) pix[i] = 8'($urandom);
      run_job($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    reset_mid_load();
    for (int i = 0; i < 4; i++) pix[i] = 8'($urandom);
    run_job(2, 2, 0, 0, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
